// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: multi-cycle front end that drives a narrow
// combinational ALU one slice per cycle, least-significant slice first.
// The carry is chained from slice to slice through a register.
// The assembled wide result, the final carry and a zero flag are
// returned over a valid/ready handshake.
module alu_wide_sequencer #(
  parameter int WIDTH  = 16,
  parameter int SLICES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  // operation input handshake
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SLICES*WIDTH-1:0]   in_a,
  input  logic [SLICES*WIDTH-1:0]   in_b,
  input  logic                      in_ci,
  input  logic [3:0]                in_S,
  input  logic                      in_M,
  // connection to the external narrow ALU
  output logic [WIDTH-1:0]          alu_a,
  output logic [WIDTH-1:0]          alu_b,
  output logic                      alu_ci,
  output logic [3:0]                alu_S,
  output logic                      alu_M,
  input  logic [WIDTH-1:0]          alu_s,
  input  logic                      alu_co,
  // result output handshake
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SLICES*WIDTH-1:0]   out_s,
  output logic                      out_co,
  output logic                      out_zero
);

  localparam int OPW  = SLICES * WIDTH;
  localparam int IDXW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [OPW-1:0]   a_q, a_d;
  logic [OPW-1:0]   b_q, b_d;
  logic [OPW-1:0]   res_q, res_d;
  logic [3:0]       func_q, func_d;
  logic             mode_q, mode_d;
  logic             co_q, co_d;
  logic             zero_q, zero_d;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      func_q  <= 4'd0;
      mode_q  <= 1'b0;
      co_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      func_q  <= func_d;
      mode_q  <= mode_d;
      co_q    <= co_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state logic: capture on accept, fold one ALU slice per RUN cycle,
  // then hold the result until the consumer takes it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    func_d  = func_q;
    mode_d  = mode_q;
    co_d    = co_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          func_d  = in_S;
          mode_d  = in_M;
          carry_d = in_ci;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        res_d[idx_q*WIDTH +: WIDTH] = alu_s;
        carry_d = alu_co;
        if (idx_q == LAST_IDX) begin
          co_d    = alu_co;
          zero_d  = (res_d == '0);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_s     = res_q;
  assign out_co    = co_q;
  assign out_zero  = zero_q;

  // The ALU only sees live operands while a slice is being computed.
  assign alu_a  = (state_q == RUN) ? a_q[idx_q*WIDTH +: WIDTH] : '0;
  assign alu_b  = (state_q == RUN) ? b_q[idx_q*WIDTH +: WIDTH] : '0;
  assign alu_ci = (state_q == RUN) ? carry_q : 1'b0;
  assign alu_S  = func_q;
  assign alu_M  = mode_q;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Testbench for alu_wide_sequencer: models the external narrow ALU and
// checks wide results against a full-width reference through a queue.
module tb_alu_wide_sequencer;

  localparam int W   = 16;
  localparam int N   = 2;
  localparam int OPW = W * N;

  typedef struct packed {
    logic [OPW-1:0] s;
    logic           co;
    logic           zero;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           inValid;
  logic           inReady;
  logic [OPW-1:0] inA;
  logic [OPW-1:0] inB;
  logic           inCi;
  logic [3:0]     inS;
  logic           inM;
  logic [W-1:0]   aluA;
  logic [W-1:0]   aluB;
  logic           aluCi;
  logic [3:0]     aluS;
  logic           aluM;
  logic [W-1:0]   aluSum;
  logic           aluCo;
  logic           outValid;
  logic           outReady;
  logic [OPW-1:0] outS;
  logic           outCo;
  logic           outZero;

  exp_t expQ[$];
  int   vectors;
  int   miscompares;
  int   cycleCount;
  int   lastAccept;

  alu_wide_sequencer #(.WIDTH(W), .SLICES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_ready (inReady),
    .in_a     (inA),
    .in_b     (inB),
    .in_ci    (inCi),
    .in_S     (inS),
    .in_M     (inM),
    .alu_a    (aluA),
    .alu_b    (aluB),
    .alu_ci   (aluCi),
    .alu_S    (aluS),
    .alu_M    (aluM),
    .alu_s    (aluSum),
    .alu_co   (aluCo),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_s    (outS),
    .out_co   (outCo),
    .out_zero (outZero)
  );

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running cycle counter used for throughput measurement
  always @(posedge clk) begin
    cycleCount = cycleCount + 1;
  end

  // Combinational model of the attached 16-bit ALU slice
  always_comb begin
    logic [W:0] sum;
    sum = '0;
    case ({aluM, aluS})
      5'b0_1001: sum = {1'b0, aluA} + {1'b0, aluB} + {{W{1'b0}}, aluCi};
      5'b0_0110: sum = {1'b0, aluA} + {1'b0, ~aluB} + {{W{1'b0}}, aluCi};
      5'b1_0110: sum = {1'b0, aluA ^ aluB};
      5'b1_1011: sum = {1'b0, aluA & aluB};
      5'b1_1110: sum = {1'b0, aluA | aluB};
      5'b1_0000: sum = {1'b0, ~aluA};
      default:   sum = {1'b0, aluA};
    endcase
    aluSum = sum[W-1:0];
    aluCo  = sum[W];
  end

  // Full-width reference of the wide operation
  function automatic exp_t refModel(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                    input logic ci, input logic [3:0] s, input logic m);
    logic [OPW:0] sum;
    exp_t e;
    case ({m, s})
      5'b0_1001: sum = {1'b0, a} + {1'b0, b} + {{OPW{1'b0}}, ci};
      5'b0_0110: sum = {1'b0, a} + {1'b0, ~b} + {{OPW{1'b0}}, ci};
      5'b1_0110: sum = {1'b0, a ^ b};
      5'b1_1011: sum = {1'b0, a & b};
      5'b1_1110: sum = {1'b0, a | b};
      5'b1_0000: sum = {1'b0, ~a};
      default:   sum = {1'b0, a};
    endcase
    e.s    = sum[OPW-1:0];
    e.co   = sum[OPW];
    e.zero = (sum[OPW-1:0] == '0);
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation and push its expected result; returns #1 after the accept edge
  task automatic applyStimulus(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                               input logic ci, input logic [3:0] s, input logic m);
    for (int i = 0; i < 50 && !inReady; i++) cyc();
    if (!inReady) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_wait: in_ready=%0b required 1 within 50 cycles", inReady);
    end
    inA = a; inB = b; inCi = ci; inS = s; inM = m;
    inValid = 1'b1;
    expQ.push_back(refModel(a, b, ci, s, m));
    cyc();
    lastAccept = cycleCount;
    inValid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; edges counts edges from the accept edge inclusive
  task automatic waitOut(output int edges, output bit seen);
    edges = 1;
    seen  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (outValid) begin
        seen = 1'b1;
        break;
      end
      cyc();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inValid = 1'b0; inA = '0; inB = '0; inCi = 1'b0; inS = 4'd0; inM = 1'b0;
    outReady = 1'b0;
    cyc(); cyc();
    vectors++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_handshake: in_ready=%0b out_valid=%0b required 1/0", inReady, outValid);
    end
    vectors++;
    if ({outS, outCo, outZero} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_result: out_s=%h co=%0b zero=%0b required all 0", outS, outCo, outZero);
    end
    vectors++;
    if ({aluA, aluB, aluCi, aluS, aluM} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_alu_ports: a=%h b=%h ci=%0b S=%h M=%0b required all 0",
               aluA, aluB, aluCi, aluS, aluM);
    end
    rst = 1'b0;
    cyc(); cyc();
    vectors++;
    if (inReady !== 1'b1 || outValid !== 1'b0 || aluA !== '0) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: in_ready=%0b out_valid=%0b alu_a=%h required 1/0/0",
               inReady, outValid, aluA);
    end
  endtask

  task automatic test_add_chain();
    exp_t e;
    outReady = 1'b1;
    applyStimulus(32'h0000FFFF, 32'h00000001, 1'b0, 4'b1001, 1'b0);
    vectors++;
    if (aluA !== 16'hFFFF || aluB !== 16'h0001 || aluCi !== 1'b0 || aluS !== 4'b1001 || aluM !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL add_slice0_ports: a=%h b=%h ci=%0b S=%h M=%0b required FFFF/0001/0/9/0",
               aluA, aluB, aluCi, aluS, aluM);
    end
    vectors++;
    if (inReady !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL add_ready_in_run: in_ready=%0b required 0", inReady);
    end
    cyc();
    vectors++;
    if (aluA !== 16'h0000 || aluB !== 16'h0000 || aluCi !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL add_slice1_ports: a=%h b=%h ci=%0b required 0000/0000/1", aluA, aluB, aluCi);
    end
    cyc();
    vectors++;
    if (outValid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL add_latency: out_valid=%0b at accept+3 required 1", outValid);
    end
    e = expQ.pop_front();
    vectors++;
    if (outS !== e.s || outCo !== e.co || outZero !== e.zero) begin
      miscompares++;
      $display("[TB] FAIL add_result: got %h/%0b/%0b required %h/%0b/%0b",
               outS, outCo, outZero, e.s, e.co, e.zero);
    end
    cyc();
    vectors++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL add_return_idle: in_ready=%0b out_valid=%0b required 1/0", inReady, outValid);
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    int edges;
    bit seen;
    outReady = 1'b0;
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 4'b1001, 1'b0);
    waitOut(edges, seen);
    vectors++;
    if (!seen || edges != N + 1) begin
      miscompares++;
      $display("[TB] FAIL ovf_latency: seen=%0b edges=%0d required 1/%0d", seen, edges, N + 1);
    end
    vectors++;
    if (aluA !== '0 || aluB !== '0 || aluCi !== 1'b0 || aluS !== 4'b1001 || aluM !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ovf_alu_in_done: a=%h b=%h ci=%0b S=%h M=%0b required 0/0/0/9/0",
               aluA, aluB, aluCi, aluS, aluM);
    end
    e = expQ.pop_front();
    vectors++;
    if (outS !== e.s || outCo !== e.co || outZero !== e.zero) begin
      miscompares++;
      $display("[TB] FAIL ovf_result: got %h/%0b/%0b required %h/%0b/%0b",
               outS, outCo, outZero, e.s, e.co, e.zero);
    end
    outReady = 1'b1;
    cyc();
    outReady = 1'b0;
  endtask

  task automatic test_logic_xor();
    exp_t e;
    int edges;
    bit seen;
    bit spurious;
    outReady = 1'b1;
    applyStimulus(32'h12345678, 32'h12345678, 1'b1, 4'b0110, 1'b1);
    inA = 32'hDEADBEEF; inB = 32'h00000001; inS = 4'b1001; inM = 1'b0;
    inValid = 1'b1;
    vectors++;
    if (inReady !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL xor_ready_in_run: in_ready=%0b required 0", inReady);
    end
    waitOut(edges, seen);
    e = expQ.pop_front();
    vectors++;
    if (!seen || outS !== e.s || outCo !== e.co || outZero !== e.zero) begin
      miscompares++;
      $display("[TB] FAIL xor_result: seen=%0b got %h/%0b/%0b required %h/%0b/%0b",
               seen, outS, outCo, outZero, e.s, e.co, e.zero);
    end
    inValid = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (outValid) spurious = 1'b1;
    end
    vectors++;
    if (spurious !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL xor_ignored_input: spurious out_valid=%0b required 0", spurious);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int edges;
    bit seen;
    outReady = 1'b0;
    applyStimulus(32'hA5A50F0F, 32'h1234F0F1, 1'b0, 4'b1001, 1'b0);
    waitOut(edges, seen);
    e = expQ.pop_front();
    vectors++;
    if (!seen || outS !== e.s || outCo !== e.co || outZero !== e.zero) begin
      miscompares++;
      $display("[TB] FAIL bp_result: seen=%0b got %h/%0b/%0b required %h/%0b/%0b",
               seen, outS, outCo, outZero, e.s, e.co, e.zero);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (outValid !== 1'b1 || outS !== e.s) begin
        miscompares++;
        $display("[TB] FAIL bp_hold%0d: out_valid=%0b out_s=%h required 1/%h", i, outValid, outS, e.s);
      end
      cyc();
    end
    outReady = 1'b1;
    cyc();
    vectors++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_release: in_ready=%0b out_valid=%0b required 1/0", inReady, outValid);
    end
    outReady = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit spurious;
    outReady = 1'b1;
    applyStimulus(32'hCAFEF00D, 32'h11111111, 1'b1, 4'b1001, 1'b0);
    rst = 1'b1;
    #1;
    vectors++;
    if (inReady !== 1'b1 || outValid !== 1'b0 || {outS, outCo, outZero} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midrst_outputs: in_ready=%0b out_valid=%0b out_s=%h co=%0b zero=%0b required 1/0/0/0/0",
               inReady, outValid, outS, outCo, outZero);
    end
    vectors++;
    if ({aluA, aluB, aluCi, aluS, aluM} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midrst_alu_ports: a=%h b=%h ci=%0b S=%h M=%0b required all 0",
               aluA, aluB, aluCi, aluS, aluM);
    end
    void'(expQ.pop_back());
    cyc();
    rst = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (outValid) spurious = 1'b1;
    end
    vectors++;
    if (spurious !== 1'b0 || inReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_aborted: spurious=%0b in_ready=%0b required 0/1", spurious, inReady);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int edges;
    bit seen;
    int firstAccept;
    outReady = 1'b1;
    applyStimulus(32'h00010002, 32'h00030004, 1'b0, 4'b0110, 1'b0);
    firstAccept = lastAccept;
    cyc();
    cyc();
    e = expQ.pop_front();
    vectors++;
    if (outValid !== 1'b1 || outS !== e.s || outCo !== e.co || outZero !== e.zero) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: valid=%0b got %h/%0b/%0b required 1/%h/%0b/%0b",
               outValid, outS, outCo, outZero, e.s, e.co, e.zero);
    end
    applyStimulus(32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 4'b1110, 1'b1);
    vectors++;
    if (lastAccept - firstAccept != N + 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_throughput: accept spacing=%0d required %0d", lastAccept - firstAccept, N + 2);
    end
    waitOut(edges, seen);
    e = expQ.pop_front();
    vectors++;
    if (!seen || outS !== e.s || outCo !== e.co || outZero !== e.zero) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: seen=%0b got %h/%0b/%0b required %h/%0b/%0b",
               seen, outS, outCo, outZero, e.s, e.co, e.zero);
    end
    cyc();
  endtask

  task automatic test_random();
    exp_t e;
    int edges;
    bit seen;
    logic [4:0] ops [5];
    logic [4:0] op;
    ops[0] = 5'b0_1001; ops[1] = 5'b0_0110; ops[2] = 5'b1_0110;
    ops[3] = 5'b1_1011; ops[4] = 5'b1_1110;
    for (int n = 0; n < 12; n++) begin
      op = ops[$urandom_range(0, 4)];
      outReady = 1'($urandom_range(0, 1));
      applyStimulus($urandom, (n == 5) ? 32'hFFFFFFFF : $urandom, 1'($urandom_range(0, 1)), op[3:0], op[4]);
      waitOut(edges, seen);
      e = expQ.pop_front();
      vectors++;
      if (!seen || outS !== e.s || outCo !== e.co || outZero !== e.zero) begin
        miscompares++;
        $display("[TB] FAIL rand%0d op=%b: seen=%0b got %h/%0b/%0b required %h/%0b/%0b",
                 n, op, seen, outS, outCo, outZero, e.s, e.co, e.zero);
      end
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) cyc();
      outReady = 1'b1;
      cyc();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cycleCount  = 0;
    lastAccept  = 0;
    test_reset();
    test_add_chain();
    test_overflow();
    test_logic_xor();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog against a stuck handshake
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_wide_sequencer.md
# alu_wide_sequencer

Multi-cycle front end for the 16-bit carry-lookahead ALU slice. It accepts one wide operation (SLICES×WIDTH bits) over a valid/ready handshake. It then drives the external `alu_16bits` instance one slice per cycle, least-significant first, chaining each slice's carry-out into the next slice's carry-in through a register. The assembled result, final carry and zero flag are returned over a second valid/ready handshake. It sits directly upstream of the ALU and lets one narrow ALU compute 32-bit (default) results.

## Interface
- `WIDTH`, 16: slice width; must match the attached ALU.
- `SLICES`, 2: number of slices per operation (≥2); the operand width is SLICES×WIDTH.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: an operation is presented.
- `in_ready` output 1: the block can accept an operation.
- `in_a`, `in_b` input SLICES×WIDTH: operands.
- `in_ci` input 1: carry-in for the least-significant slice.
- `in_S` input 4: ALU function select.
- `in_M` input 1: ALU mode (1 = logic, 0 = arithmetic).
- `alu_a`, `alu_b` output WIDTH: current slice operands to the ALU.
- `alu_ci` output 1: current slice carry-in to the ALU.
- `alu_S` output 4, `alu_M` output 1: function and mode to the ALU.
- `alu_s` input WIDTH: ALU sum for the current slice (combinational from `alu_*`).
- `alu_co` input 1: ALU carry-out for the current slice.
- `out_valid` output 1: a result is available.
- `out_ready` input 1: the consumer accepts the result.
- `out_s` output SLICES×WIDTH: assembled result.
- `out_co` output 1: carry-out of the most-significant slice.
- `out_zero` output 1: high when `out_s` is all zeros.

## Operation
- FSM states are IDLE, RUN and DONE. A slice counter `idx` spans 0..SLICES-1.
- **IDLE:**
  - `in_ready`=1.
  - When `in_valid`&`in_ready`, the block registers `in_a`, `in_b`, `in_S` and `in_M`, sets `carry_q`←`in_ci` and `idx`←0, and moves to RUN.
- **RUN:**
  - `alu_a`/`alu_b` = slice `idx` of the registered operands.
  - `alu_ci`=`carry_q`, and `alu_S`/`alu_M` are the registered values.
  - Each cycle, `alu_s` is written into slice `idx` of the result register and `carry_q`←`alu_co`.
  - When `idx`==SLICES-1, the block moves to DONE. Otherwise `idx`←`idx`+1.
- **Carry chaining in logic mode:** the carry is chained even when M=1. The ALU ignores ci in logic mode, so the result is unaffected; `out_co` reports the last slice's `alu_co` unmodified.
- **DONE:**
  - `out_valid`=1; `out_s`, `out_co` and `out_zero` are held stable.
  - When `out_ready`=1, the block returns to IDLE.
  - `out_valid` stays high indefinitely under backpressure.
- **Input acceptance:** `in_ready` is 0 in RUN and DONE. `in_valid` in those states is ignored and is not queued.
- **ALU port values outside RUN:** `alu_a`, `alu_b` and `alu_ci` are 0 in IDLE and DONE. `alu_S` and `alu_M` keep their registered values.
- **`out_zero`:** registered, computed from the full result when entering DONE.

## Timing
- **Reset values (async, while `rst`=1):**
  - State IDLE, `in_ready`=1.
  - `out_valid`=0, `out_s`=0, `out_co`=0, `out_zero`=0.
  - `alu_a`=`alu_b`=0, `alu_ci`=0, `alu_S`=0, `alu_M`=0.
  - `carry_q`=0, `idx`=0.
- **Latency and throughput:**
  - Accept edge at cycle T; RUN occupies T+1..T+SLICES; `out_valid` rises at T+SLICES+1 (cycle 3 for the default SLICES=2).
  - If `out_ready` is high at that edge, IDLE is reached at T+SLICES+2, giving a throughput of one operation per SLICES+2 cycles.
- **Combinational ALU path:** `alu_s` and `alu_co` are sampled in the same cycle the `alu_*` outputs are driven. The ALU is purely combinational, so the path is `alu_*` register → ALU → result register in one cycle.
- **Reset mid-operation:** a reset during RUN or DONE aborts the operation. No `out_valid` is produced for it, and all outputs return to their reset values immediately (asynchronously).
- **Parameter behaviour:**
  - `idx` width is clog2(SLICES).
  - There is no wrap hazard, because `idx` is reset on every accept.

## Test plan
- **Reset, then idle:** `in_valid`=0 → `in_ready`=1, `out_valid`=0, `alu_a`=0, all outputs 0.
- **Add with carry chaining:** `in_a`=0x0000FFFF, `in_b`=0x00000001, `in_ci`=0, S=4'b1001, M=0, `out_ready`=1.
  - Slice 0: `alu_s`=0x0000, `alu_co`=1.
  - Slice 1: `alu_ci`=1.
  - Result: `out_s`=0x00010000, `out_co`=0, `out_zero`=0, with `out_valid` at cycle T+3.
- **Full overflow:** `in_a`=0xFFFFFFFF, `in_b`=0x00000001, add mode → `out_s`=0x00000000, `out_co`=1, `out_zero`=1.
- **Logic XOR:** `in_a`=0x12345678, `in_b`=0x12345678, S=4'b0110, M=1 → `out_s`=0, `out_zero`=1.
  - `in_valid` is asserted again during RUN and must be ignored (`in_ready`=0).
- **Backpressure:** `out_ready`=0 for 5 cycles after `out_valid` → `out_valid` and `out_s` are held; the handshake on the 6th cycle returns the block to IDLE next cycle with `in_ready`=1.
- **Reset mid-RUN:** assert `rst` in cycle T+1 → `out_valid` never rises for that operation; outputs go to reset values and `in_ready`=1 after `rst` deasserts.
